// File: rtl/suite_pkg.sv
// suite_pkg: shared types and defaults for the suite image loader path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package suite_pkg;

  // Loader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // First-error codes reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_ADDR     = 2'd2,
    ERR_SIZE     = 2'd3
  } loader_err_t;

  // One RAM write as it sits in the word FIFO.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } loader_word_t;

  localparam int LOADER_MAX_BYTES  = 131072;
  localparam int LOADER_FIFO_DEPTH = 4;

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous show-ahead FIFO holding packed RAM words.
// Latency: a push is visible on dout the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module loader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign last      = (r_count == ONE_CNT);
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);
  // Zero when empty so the RAM port shows clean values after reset or clear.
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking with synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_loader.sv
// image_loader: packs the HPS download byte stream into little-endian 16-bit image RAM writes.
// Latency: odd byte strobed on cycle N gives mem_we on cycle N+1 when the FIFO was empty.
// Backpressure: mem_ready stalls the FIFO head; ioctl is never stalled, so a full FIFO drops the word and flags overflow.
module image_loader
  import suite_pkg::*;
#(
  parameter int MAX_BYTES  = LOADER_MAX_BYTES,
  parameter int FIFO_DEPTH = LOADER_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        busy,
  output logic        loaded,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [17:0] byte_count,
  output logic [15:0] checksum
);

  localparam logic [17:0] MAX_BYTES_W = 18'(MAX_BYTES);

  loader_state_t r_state;
  loader_state_t w_state_nxt;
  logic          r_dl_d;
  logic [17:0]   r_byte_count;
  logic [15:0]   r_checksum;
  logic [7:0]    r_pend;
  logic          r_pend_vld;
  logic          r_error;
  loader_err_t   r_err_code;
  logic          r_loaded;

  logic          w_dl_rise;
  logic          w_accept;
  logic          w_bad_addr;
  logic          w_too_big;
  logic          w_push;
  logic          w_flush_push;
  logic          w_overflow;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_last;
  logic          w_busy;
  loader_word_t  w_push_word;
  loader_word_t  w_head;

  // A new download window restarts everything, whatever state we were in.
  assign w_dl_rise  = ioctl_download & ~r_dl_d;
  assign w_pop      = ~w_empty & mem_ready;
  // Only byte-path pushes can overflow; the flush push waits for room.
  assign w_overflow = w_push & w_full & ~w_pop;

  assign mem_we     = ~w_empty;
  assign mem_addr   = w_head.addr;
  assign mem_data   = w_head.data;
  assign busy       = w_busy;
  assign loaded     = r_loaded;
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign byte_count = r_byte_count;
  assign checksum   = r_checksum;

  loader_fifo #(
    .WIDTH ($bits(loader_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (w_dl_rise),
    .push  (w_push),
    .din   (w_push_word),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .last  (w_last)
  );

  // Registered copy of ioctl_download for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl_d <= 1'b0;
    end else begin
      r_dl_d <= ioctl_download;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, byte acceptance, packing and flush decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_bad_addr   = 1'b0;
    w_too_big    = 1'b0;
    w_push       = 1'b0;
    w_flush_push = 1'b0;
    w_push_word  = '0;
    w_busy       = (r_state == LOAD) || (r_state == FLUSH);
    if (w_dl_rise) begin
      w_state_nxt = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (!ioctl_download) begin
            w_state_nxt = FLUSH;
          end else if (ioctl_wr) begin
            if (ioctl_addr != r_byte_count[16:0]) begin
              w_bad_addr = 1'b1;
            end else if (r_byte_count >= MAX_BYTES_W) begin
              w_too_big = 1'b1;
            end else begin
              w_accept = 1'b1;
              if (ioctl_addr[0]) begin
                w_push           = 1'b1;
                w_push_word.addr = ioctl_addr[16:1];
                w_push_word.data = {ioctl_dout, r_pend};
              end
            end
          end
        end
        FLUSH: begin
          if (r_pend_vld) begin
            // Odd-length tail: byte_count is odd here, so [16:1] is the pending word address.
            if (!w_full || w_pop) begin
              w_push           = 1'b1;
              w_flush_push     = 1'b1;
              w_push_word.addr = r_byte_count[16:1];
              w_push_word.data = {8'h00, r_pend};
            end
          end else if (w_empty || (w_last && w_pop)) begin
            w_state_nxt = DONE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Byte count, checksum and pending even byte.
  always_ff @(posedge clk) begin
    if (reset || w_dl_rise) begin
      r_byte_count <= '0;
      r_checksum   <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_byte_count <= r_byte_count + 18'd1;
        r_checksum   <= r_checksum + {8'h00, ioctl_dout};
        if (!ioctl_addr[0]) begin
          r_pend     <= ioctl_dout;
          r_pend_vld <= 1'b1;
        end else begin
          r_pend_vld <= 1'b0;
        end
      end else if (w_flush_push) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Sticky error flag; only the first cause is kept in err_code.
  always_ff @(posedge clk) begin
    if (reset || w_dl_rise) begin
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (!r_error) begin
      if (w_overflow) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_OVERFLOW;
      end else if (w_bad_addr) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_ADDR;
      end else if (w_too_big) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_SIZE;
      end
    end
  end

  // loaded is captured as FLUSH hands over to DONE, once the last word has left.
  always_ff @(posedge clk) begin
    if (reset || w_dl_rise) begin
      r_loaded <= 1'b0;
    end else if ((r_state == FLUSH) && (w_state_nxt == DONE)) begin
      r_loaded <= ~r_error;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: scoreboard bench for image_loader download, packing, overflow and recovery.
// Latency: checks byte_count/checksum one cycle after each strobe and first mem_we one cycle after an odd byte.
// Backpressure: drives mem_ready low to force FIFO overflow, then releases it to drain.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_we;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        loaded;
  logic        error;
  logic [1:0]  err_code;
  logic [17:0] byte_count;
  logic [15:0] checksum;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  image_loader #(
    .MAX_BYTES  (131072),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .busy           (busy),
    .loaded         (loaded),
    .error          (error),
    .err_code       (err_code),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  // One cycle: the RAM side is sampled on the falling edge, inputs then change 1ns after the rising edge.
  task automatic tick();
    logic [31:0] exp_w;
    @(negedge clk);
    if (mem_we && mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_write: got addr=%h data=%h, required no write", mem_addr, mem_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_data} !== exp_w) begin
          errors++;
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_data, exp_w[31:16], exp_w[15:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [16:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic finish_dl(input int limit);
    bit done;
    done = 1'b0;
    ioctl_download = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL flush_timeout: busy=1 after %0d cycles, required 0", limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (loaded !== 1'b0)      begin errors++; $display("FAIL rst_loaded: got %b required 0", loaded); end
    checks++; if (error !== 1'b0)       begin errors++; $display("FAIL rst_error: got %b required 0", error); end
    checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    checks++; if (err_code !== 2'd0)    begin errors++; $display("FAIL rst_err_code: got %0d required 0", err_code); end
    checks++; if (byte_count !== 18'd0) begin errors++; $display("FAIL rst_byte_count: got %0d required 0", byte_count); end
    checks++; if (checksum !== 16'd0)   begin errors++; $display("FAIL rst_checksum: got %h required 0000", checksum); end
    checks++; if ({mem_addr, mem_data} !== 32'd0) begin
      errors++; $display("FAIL rst_mem_bus: got %h required 00000000", {mem_addr, mem_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_even_image();
    mem_ready = 1'b1;
    start_dl();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL even_busy: got %b required 1", busy); end
    send_byte(17'd0, 8'h01);
    checks++; if (byte_count !== 18'd1) begin errors++; $display("FAIL even_count_lat: got %0d required 1", byte_count); end
    checks++; if (checksum !== 16'h0001) begin errors++; $display("FAIL even_sum_lat: got %h required 0001", checksum); end
    exp_q.push_back({16'd0, 16'h0201});
    send_byte(17'd1, 8'h02);
    checks++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'd0, 16'h0201}) begin
      errors++; $display("FAIL even_first_word_lat: got we=%b %h/%h required we=1 0000/0201", mem_we, mem_addr, mem_data);
    end
    send_byte(17'd2, 8'h03);
    exp_q.push_back({16'd1, 16'h0403});
    send_byte(17'd3, 8'h04);
    send_byte(17'd4, 8'h05);
    exp_q.push_back({16'd2, 16'h0605});
    send_byte(17'd5, 8'h06);
    finish_dl(50);
    checks++; if (byte_count !== 18'd6)  begin errors++; $display("FAIL even_count: got %0d required 6", byte_count); end
    checks++; if (checksum !== 16'h0015) begin errors++; $display("FAIL even_sum: got %h required 0015", checksum); end
    checks++; if (loaded !== 1'b1)       begin errors++; $display("FAIL even_loaded: got %b required 1", loaded); end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL even_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_odd_image();
    mem_ready = 1'b1;
    start_dl();
    send_byte(17'd0, 8'hAA);
    exp_q.push_back({16'd0, 16'hBBAA});
    send_byte(17'd1, 8'hBB);
    send_byte(17'd2, 8'hCC);
    exp_q.push_back({16'd1, 16'h00CC});
    finish_dl(50);
    checks++; if (byte_count !== 18'd3)  begin errors++; $display("FAIL odd_count: got %0d required 3", byte_count); end
    checks++; if (checksum !== 16'h0231) begin errors++; $display("FAIL odd_sum: got %h required 0231", checksum); end
    checks++; if (loaded !== 1'b1)       begin errors++; $display("FAIL odd_loaded: got %b required 1", loaded); end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL odd_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0] b [10];
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) b[i] = 8'h10 + 8'(i);
    start_dl();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1 && i < 8) exp_q.push_back({16'(i / 2), b[i], b[i-1]});
      send_byte(17'(i), b[i]);
    end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL ovf_code: got %0d required 1", err_code); end
    checks++; if (error !== 1'b1)    begin errors++; $display("FAIL ovf_error: got %b required 1", error); end
    checks++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'd0, 16'h1110}) begin
      errors++; $display("FAIL ovf_head_stable: got we=%b %h/%h required we=1 0000/1110", mem_we, mem_addr, mem_data);
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    mem_ready = 1'b1;
    finish_dl(50);
    checks++; if (loaded !== 1'b0)   begin errors++; $display("FAIL ovf_loaded: got %b required 0", loaded); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL ovf_code_end: got %0d required 1", err_code); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_addr_seq();
    mem_ready = 1'b1;
    start_dl();
    send_byte(17'd0, 8'h21);
    exp_q.push_back({16'd0, 16'h2221});
    send_byte(17'd1, 8'h22);
    send_byte(17'd3, 8'h23);
    checks++; if (err_code !== 2'd2)    begin errors++; $display("FAIL seq_code: got %0d required 2", err_code); end
    checks++; if (byte_count !== 18'd2) begin errors++; $display("FAIL seq_count: got %0d required 2", byte_count); end
    finish_dl(50);
    checks++; if (checksum !== 16'h0043) begin errors++; $display("FAIL seq_sum: got %h required 0043", checksum); end
    checks++; if (loaded !== 1'b0)       begin errors++; $display("FAIL seq_loaded: got %b required 0", loaded); end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL seq_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    start_dl();
    checks++; if ({error, err_code, loaded} !== 4'b0000) begin
      errors++; $display("FAIL b2b_clear: got error=%b code=%0d loaded=%b required 0/0/0", error, err_code, loaded);
    end
    checks++; if (byte_count !== 18'd0) begin errors++; $display("FAIL b2b_count_clear: got %0d required 0", byte_count); end
    send_byte(17'd0, 8'h5A);
    exp_q.push_back({16'd0, 16'hA55A});
    send_byte(17'd1, 8'hA5);
    send_byte(17'd2, 8'h01);
    exp_q.push_back({16'd1, 16'hFF01});
    send_byte(17'd3, 8'hFF);
    finish_dl(50);
    checks++; if (loaded !== 1'b1)       begin errors++; $display("FAIL b2b_loaded: got %b required 1", loaded); end
    checks++; if (err_code !== 2'd0)     begin errors++; $display("FAIL b2b_code: got %0d required 0", err_code); end
    checks++; if (checksum !== 16'h01FF) begin errors++; $display("FAIL b2b_sum: got %h required 01ff", checksum); end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL b2b_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    start_dl();
    send_byte(17'd0, 8'h31);
    send_byte(17'd1, 8'h32);
    send_byte(17'd2, 8'h33);
    send_byte(17'd3, 8'h34);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmid_queued: got we=%b required 1", mem_we); end
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    checks++; if ({busy, loaded, error, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL rmid_flags: got busy/loaded/error/we=%b%b%b%b required 0000", busy, loaded, error, mem_we);
    end
    checks++; if ({err_code, byte_count, checksum} !== 36'd0) begin
      errors++; $display("FAIL rmid_status: got code=%0d count=%0d sum=%h required 0/0/0000", err_code, byte_count, checksum);
    end
    checks++; if ({mem_addr, mem_data} !== 32'd0) begin
      errors++; $display("FAIL rmid_bus: got %h required 00000000", {mem_addr, mem_data});
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_no_we: got we=%b at cycle %0d required 0", mem_we, i); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    mem_ready      = 1'b0;
    test_reset();
    test_even_image();
    test_odd_image();
    test_overflow();
    test_addr_seq();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Byte-stream image loader sitting directly upstream of `suite`: consumes the HPS download stream (`ioctl_*`) and writes the image into the suite's 16-bit image RAM port. It packs byte pairs into little-endian words, absorbs RAM-side backpressure in a small FIFO, and tracks byte count, checksum and protocol errors. It raises `loaded` once a clean image is fully committed to RAM.

## Interface
- `MAX_BYTES`, 131072: largest accepted image in bytes; must be even and ≤ 2^17.
- `FIFO_DEPTH`, 4: word FIFO depth; must be a power of two ≥ 2.
- `clk` in 1: system clock (`clk_sys` domain).
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: download window active.
- `ioctl_wr` in 1: byte strobe, one cycle per byte; never stalled.
- `ioctl_addr` in 17: byte address of `ioctl_dout`.
- `ioctl_dout` in 8: download byte.
- `mem_we` out 1: word write request.
- `mem_ready` in 1: RAM accepts the word this cycle; a transfer occurs when `mem_we & mem_ready`.
- `mem_addr` out 16: word address, `ioctl_addr[16:1]` of the pair.
- `mem_data` out 16: `{odd byte, even byte}`.
- `busy` out 1: load or flush in progress.
- `loaded` out 1: last download completed without error.
- `error` out 1: sticky until the next download starts or `reset`.
- `err_code` out 2: 0 none, 1 FIFO overflow, 2 address out of sequence, 3 size over `MAX_BYTES`.
- `byte_count` out 18: bytes accepted in the current or last download.
- `checksum` out 16: sum of accepted bytes, modulo 2^16.

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- Transitions:
  - Rising `ioctl_download` in any state, including mid-FLUSH: go to LOAD. Clear `loaded`, `error`, `err_code`, `byte_count`, `checksum`, the pending byte and the FIFO.
  - LOAD with `ioctl_download` low: go to FLUSH.
  - FLUSH with the pending byte pushed and the FIFO empty: go to DONE.
  - DONE: hold until the next rising edge of `ioctl_download`.
- Accepting a byte in LOAD (`ioctl_wr` high):
  - Expected address is `byte_count[16:0]`. A mismatch sets `err_code=2`; the byte is dropped.
  - `byte_count ≥ MAX_BYTES` sets `err_code=3`; the byte is dropped.
  - Otherwise `byte_count += 1` and `checksum += byte`.
- Packing:
  - An even-address byte is held in the pending register.
  - An odd-address byte completes the word, which is pushed to the FIFO with `mem_addr = addr[16:1]`.
- FIFO overflow: a push while the FIFO is full drops the word, sets `err_code=1` and sets `error`. Loading continues.
- Only the first error code is recorded; later errors leave `err_code` unchanged.
- FLUSH with a pending even byte: push `{8'h00, pending}` as one word. Odd-length images are legal.
- DONE: `loaded = ~error`.
- `ioctl_wr` is ignored outside LOAD, and also ignored while `ioctl_download` is low.
- `mem_we = ~fifo_empty`. `mem_addr`/`mem_data` present the FIFO head and are stable while `mem_we & ~mem_ready`.
- A push and a pop in the same cycle are both honoured; the count is unchanged, and with a full FIFO this is not an overflow.

## Timing
- Reset values:
  - Outputs `busy`, `loaded`, `error`, `mem_we` = 0; `err_code` = 0; `byte_count` = 0; `checksum` = 0; `mem_addr`/`mem_data` = 0.
  - State: IDLE.
  - FIFO: empty.
- Reset mid-load aborts silently: the FIFO is discarded and no further `mem_we` is issued.
- Latency: odd byte on cycle N → `mem_we` high on cycle N+1, with the word at the FIFO head, if the FIFO was empty.
- `byte_count` and `checksum` update on the cycle after the strobe.
- `busy` is high in LOAD and FLUSH. It goes high the cycle after the rising edge of `ioctl_download`.
- `loaded` rises the cycle after the last FIFO pop in FLUSH, or the cycle after entering FLUSH if nothing is pending.
- Sustained throughput: one word per cycle. With `mem_ready` continuously high the FIFO never exceeds 1 entry.

## Structure
- Shared package `suite_pkg`:
  - `loader_state_t` enum: IDLE/LOAD/FLUSH/DONE.
  - `loader_err_t` 2-bit codes.
  - `LOADER_MAX_BYTES` default.
- Sub-module `loader_fifo`: synchronous show-ahead FIFO, parameterised by width (32 = 16 addr + 16 data) and depth.
  - Outputs `full`, `empty`, `dout`.
  - Simultaneous push and pop are supported.
- Rising-edge detect on `ioctl_download` is a registered delay inside `image_loader`.

## Test plan
- 6-byte download `01 02 03 04 05 06`, `mem_ready=1`:
  - Writes (0,`0201`), (1,`0403`), (2,`0605`).
  - Ends with `byte_count=6`, `checksum=0x0015`, `loaded=1`.
- 3-byte download `AA BB CC`: writes (0,`BBAA`), then (1,`00CC`) in FLUSH; `loaded=1`, `checksum=0x0231`.
- `mem_ready=0` during 10 back-to-back bytes (5 words, depth 4):
  - 5th push sets `err_code=1`, `loaded=0`.
  - After `mem_ready=1`, exactly 4 words drain in order.
- Address sequence 0,1,3: `err_code=2` and `byte_count=2`; byte at 3 never reaches RAM.
- `reset` asserted mid-download with 2 words queued: all outputs return to reset values the next cycle; no `mem_we` afterwards.
- Second download after a failed one: flags clear on its rising edge; a clean image then gives `loaded=1`, `err_code=0`.
